// File: rtl/wb_regfile_writer_pkg.sv
// Shared types and constants for the write-back stage.
// Holds register widths, load funct3 codes and the load-queue entry.
package wb_regfile_writer_pkg;

   localparam int RegBus     = 32;
   localparam int RegAddrBus = 5;

   localparam logic [RegBus-1:0] ZeroWord = '0;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;

   typedef struct packed {
      logic [RegAddrBus-1:0] rd;
      logic [2:0]            funct3;
      logic [1:0]            off;
   } lq_entry_t;

endpackage

// File: rtl/wb_load_queue.sv
// In-order queue of outstanding loads.
// Exposes the head entry and per-entry valid/rd for hazard matching.
module wb_load_queue
   import wb_regfile_writer_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int PW    = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_push,
   input  lq_entry_t             i_push_ent,
   input  logic                  i_pop,
   output lq_entry_t             o_head,
   output logic [PW:0]           o_count,
   output logic [DEPTH-1:0]      o_ent_vld,
   output logic [RegAddrBus-1:0] o_ent_rd [DEPTH]
);

   lq_entry_t     r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [PW:0]   r_count;

   // Pointer, occupancy and storage update; wrap is free for power-of-two depth
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++)
            r_mem[i] <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_ent;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (i_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;

   for (genvar g = 0; g < DEPTH; g++) begin : g_ent
      logic [PW-1:0] w_rel;
      assign w_rel        = PW'(g) - r_rd_ptr;
      assign o_ent_vld[g] = {1'b0, w_rel} < r_count;
      assign o_ent_rd[g]  = r_mem[g].rd;
   end

endmodule

// File: rtl/wb_regfile_writer.sv
// Write-back stage: merges ALU results and load responses onto
// the register-file write port, with a pending-load scoreboard.
module wb_regfile_writer
   import wb_regfile_writer_pkg::*;
#(
   parameter int DATA_W   = RegBus,
   parameter int ADDR_W   = RegAddrBus,
   parameter int LQ_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic [ADDR_W-1:0] ex_rd,
   input  logic [DATA_W-1:0] ex_data,
   input  logic              ld_issue_valid,
   output logic              ld_issue_ready,
   input  logic [ADDR_W-1:0] ld_issue_rd,
   input  logic [2:0]        ld_issue_funct3,
   input  logic [1:0]        ld_issue_off,
   input  logic              ld_rsp_valid,
   output logic              ld_rsp_ready,
   input  logic [DATA_W-1:0] ld_rsp_data,
   input  logic [ADDR_W-1:0] rs1_addr,
   input  logic [ADDR_W-1:0] rs2_addr,
   output logic              rs1_busy,
   output logic              rs2_busy,
   output logic              regwrite,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   localparam int PW = $clog2(LQ_DEPTH);

   lq_entry_t             w_head;
   lq_entry_t             w_push_ent;
   logic [PW:0]           w_count;
   logic [LQ_DEPTH-1:0]   w_ent_vld;
   logic [RegAddrBus-1:0] w_ent_rd [LQ_DEPTH];
   logic                  w_nempty;
   logic                  w_full;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_waw_hit;
   logic                  w_rs1_hit;
   logic                  w_rs2_hit;
   logic                  w_waw;
   logic [7:0]            w_byte;
   logic [15:0]           w_half;
   logic [DATA_W-1:0]     w_ld_data;
   logic                  w_gnt;
   logic [ADDR_W-1:0]     w_gnt_rd;
   logic [DATA_W-1:0]     w_gnt_data;

   assign w_nempty = w_count != '0;
   assign w_full   = w_count == (PW+1)'(LQ_DEPTH);

   assign ld_issue_ready = rst & ~w_full;
   assign ld_rsp_ready   = rst & w_nempty;

   assign w_push = ld_issue_valid & ld_issue_ready;
   assign w_pop  = ld_rsp_valid & ld_rsp_ready;

   assign w_push_ent = '{rd:     ld_issue_rd,
                         funct3: ld_issue_funct3,
                         off:    ld_issue_off};

   wb_load_queue #(
      .DEPTH (LQ_DEPTH),
      .PW    (PW)
   ) u_lq (
      .clk        (clk),
      .rst        (rst),
      .i_push     (w_push),
      .i_push_ent (w_push_ent),
      .i_pop      (w_pop),
      .o_head     (w_head),
      .o_count    (w_count),
      .o_ent_vld  (w_ent_vld),
      .o_ent_rd   (w_ent_rd)
   );

   // Compare every live queue entry against the ALU and ID register indices
   always_comb begin
      w_waw_hit = 1'b0;
      w_rs1_hit = 1'b0;
      w_rs2_hit = 1'b0;
      for (int i = 0; i < LQ_DEPTH; i++) begin
         if (w_ent_vld[i] && w_ent_rd[i] == ex_rd)
            w_waw_hit = 1'b1;
         if (w_ent_vld[i] && w_ent_rd[i] == rs1_addr)
            w_rs1_hit = 1'b1;
         if (w_ent_vld[i] && w_ent_rd[i] == rs2_addr)
            w_rs2_hit = 1'b1;
      end
   end

   // An ALU write to a register with a load in flight must wait so it lands last
   assign w_waw    = w_waw_hit & (ex_rd != '0);
   assign ex_ready = rst & ex_valid & ~w_pop & ~w_waw;

   assign rs1_busy = rst & w_rs1_hit & (rs1_addr != '0);
   assign rs2_busy = rst & w_rs2_hit & (rs2_addr != '0);

   // Select and extend the addressed byte/half of the response word
   always_comb begin
      w_byte = ld_rsp_data[{w_head.off, 3'b000} +: 8];
      w_half = ld_rsp_data[{w_head.off[1], 4'b0000} +: 16];
      case (w_head.funct3)
         LB:      w_ld_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
         LBU:     w_ld_data = {{(DATA_W-8){1'b0}}, w_byte};
         LH:      w_ld_data = {{(DATA_W-16){w_half[15]}}, w_half};
         LHU:     w_ld_data = {{(DATA_W-16){1'b0}}, w_half};
         default: w_ld_data = ld_rsp_data;
      endcase
   end

   // Load response wins the write port; otherwise an accepted ALU result
   always_comb begin
      w_gnt      = w_pop | ex_ready;
      w_gnt_rd   = w_pop ? ADDR_W'(w_head.rd) : ex_rd;
      w_gnt_data = w_pop ? w_ld_data : ex_data;
   end

   // Registered write port; x0 writes and idle cycles leave address/data held
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         regwrite <= 1'b0;
         rd_addr  <= '0;
         rd_data  <= ZeroWord;
      end else if (w_gnt && w_gnt_rd != '0) begin
         regwrite <= 1'b1;
         rd_addr  <= w_gnt_rd;
         rd_data  <= w_gnt_data;
      end else begin
         regwrite <= 1'b0;
      end
   end

endmodule

// File: doc/wb_regfile_writer.md
Name: wb_regfile_writer

Overview:
- Write-back stage that drives the write port of the general-purpose register file: regwrite, rd_addr and rd_data.
- Merges two result sources onto the single write port:
  - in-order ALU/EX results;
  - out-of-order-arriving data-memory load responses, matched against a small in-order load queue.
- Extracts and extends load data.
- Exposes a pending-load scoreboard so ID can raise load-use stalls.

Parameters:
- DATA_W, 32, register/data width (RegBus).
- ADDR_W, 5, register index width (RegAddrBus / RegNumLog2).
- LQ_DEPTH, 2, outstanding-load queue entries (power of two, >=2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ex_valid  in  1  ALU result valid.
- ex_ready  out  1  ALU result accepted this cycle.
- ex_rd  in  ADDR_W  ALU destination.
- ex_data  in  DATA_W  ALU result.
- ld_issue_valid  in  1  load issued to memory.
- ld_issue_ready  out  1  queue can accept issue.
- ld_issue_rd  in  ADDR_W  load destination.
- ld_issue_funct3  in  3  load type.
- ld_issue_off  in  2  byte offset addr[1:0].
- ld_rsp_valid  in  1  memory read data valid.
- ld_rsp_ready  out  1  response consumed.
- ld_rsp_data  in  DATA_W  aligned 32-bit word.
- rs1_addr  in  ADDR_W  ID source 1 query.
- rs2_addr  in  ADDR_W  ID source 2 query.
- rs1_busy  out  1  rs1 has pending load.
- rs2_busy  out  1  rs2 has pending load.
- regwrite  out  1  register-file write enable.
- rd_addr  out  ADDR_W  register-file write address.
- rd_data  out  DATA_W  register-file write data.

Behaviour:
- Reset (rst=0, async):
  - queue empty, pointers 0;
  - regwrite=0, rd_addr=0, rd_data=0.
  - Combinational outputs under reset: ex_ready=0, ld_issue_ready=0, ld_rsp_ready=0, rs*_busy=0.
- Load queue: circular FIFO of {rd, funct3, off}; count 0..LQ_DEPTH.
  - ld_issue_ready = count<LQ_DEPTH.
  - Push on ld_issue_valid&ld_issue_ready.
  - Simultaneous push and pop at full is not allowed: ready is computed from the current count.
- Response: ld_rsp_ready = count!=0. A response with an empty queue is ignored.
  - Pop on ld_rsp_valid&ld_rsp_ready; the response always belongs to the head entry.
- Arbitration: a load response has priority.
  - ex_ready = ~(ld_rsp_valid&count!=0) & ~waw.
  - waw = any valid queue entry with rd==ex_rd and ex_rd!=0. This holds the ALU result so the younger write lands last.
- Write port: registered, 1-cycle latency from the accepting cycle.
  - Exactly one of load pop / ex accept is granted per cycle.
  - regwrite=1 only if the granted rd!=0; writes to x0 are dropped with regwrite=0.
  - With no grant: regwrite=0, and rd_addr/rd_data hold their last values.
- Load extraction uses the head funct3 and off:
  - 000 LB: byte[off], sign-extended.
  - 100 LBU: byte[off], zero-extended.
  - 001 LH: half[off[1]], sign-extended.
  - 101 LHU: half[off[1]], zero-extended.
  - 010 LW and any other code: full word.
- Scoreboard:
  - rsN_busy = rsN_addr!=0 and the address matches any valid queue entry, including the head being popped this cycle.
  - The register file bypasses same-cycle writes, so busy deasserts the cycle after the registered write.
- Simultaneous issue and pop of the same rd: the new entry stays busy.
- Multiple pending loads to one rd retire in queue order.
- Reset mid-operation discards queued loads. The memory side must also reset.

Decomposition:
- Shared package holds:
  - DATA_W/ADDR_W constants (RegBus, RegAddrBus);
  - load funct3 codes (LB, LH, LW, LBU, LHU);
  - the load-queue entry struct {rd, funct3, off};
  - ZeroWord.
- One sub-module, wb_load_queue: the FIFO plus its parallel rd-match outputs (per-entry valid&rd).
- Extraction, arbitration and the write register stay in the top.

Test Plan:
- Reset: hold rst=0, then release → regwrite=0, rd_addr=0, rd_data=0, ld_issue_ready=1, ex_ready=0 until the first ex_valid; then ex_valid, rd=5, data=0x1234 → next cycle regwrite=1, rd_addr=5, rd_data=0x1234.
- Issue LB to rd=7 with off=2; response 0x00800000 → rd_data=0xFFFFFF80. Repeat as LBU → 0x00000080. LH off=2 on 0x80010000 → 0xFFFF8001. LHU → 0x00008001.
- Load response and ex_valid in the same cycle (rd=3 load, rd=4 ALU) → load written first, ex_ready=0 that cycle, ALU written the following cycle.
- WAW: pending load to rd=9 plus ex_valid to rd=9 → ex_ready=0 until the load pops; final register 9 = ALU data. rs1_addr=9 → rs1_busy=1 until the pop cycle.
- Fill the queue (2 issues) → ld_issue_ready=0; third issue held; one response → ready=1. ex/load to rd=0 → regwrite=0.
- Assert rst=0 with 2 pending loads → busy=0, count=0; a later response with an empty queue → ld_rsp_ready=0, no write.
